// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - 16-bit prescaled interval timer with level IRQ (option macro: TIMER_ONESHOT_EN)
module timer_irq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  logic        en, ie, oneshot, tf;
  logic [7:0]  pre, pcnt, shadow, rdata;
  logic [15:0] reload, count;
  logic        wr, rd, ctrl_wr, stat_wr, pre_wr, rl_wr, rh_wr;
  logic        run, tick, timeout;

  assign wr      = cs & we;
  assign rd      = cs & ~we;
  assign ctrl_wr = wr && (addr == 3'd0);
  assign stat_wr = wr && (addr == 3'd1);
  assign pre_wr  = wr && (addr == 3'd2);
  assign rl_wr   = wr && (addr == 3'd3);
  assign rh_wr   = wr && (addr == 3'd4);

  // A CTRL write that clears EN cancels any tick falling on the same edge.
  assign run     = en & ~(ctrl_wr & ~din[0]);
  assign tick    = run && (pcnt == pre);
  assign timeout = tick && (count == 16'd0);
  assign irq     = tf & ie;

  always_comb begin
    rdata = 8'h00;
    case (addr)
      3'd0: rdata = {5'b00000, oneshot, ie, en};
      3'd1: rdata = {7'b0000000, tf};
      3'd2: rdata = pre;
      3'd3: rdata = reload[7:0];
      3'd4: rdata = reload[15:8];
      3'd5: rdata = count[7:0];
      3'd6: rdata = shadow;
      default: rdata = 8'h00;
    endcase
  end

`ifdef TIMER_ONESHOT_EN
  always_ff @(posedge clk) begin
    if (rst)
      oneshot <= 1'b0;
    else if (ctrl_wr)
      oneshot <= din[2];
  end
`else
  assign oneshot = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      ie     <= 1'b0;
      tf     <= 1'b0;
      pre    <= 8'h00;
      pcnt   <= 8'h00;
      reload <= 16'h0000;
      count  <= 16'h0000;
      shadow <= 8'h00;
      dout   <= 8'h00;
    end else begin
      if (!run || tick)
        pcnt <= 8'h00;
      else
        pcnt <= pcnt + 8'd1;

      if (tick)
        count <= (count == 16'd0) ? reload : count - 16'd1;

      // Timeout set wins over a simultaneous write-1-clear.
      if (timeout)
        tf <= 1'b1;
      else if (stat_wr && din[0])
        tf <= 1'b0;

      if (ctrl_wr) begin
        en <= din[0];
        ie <= din[1];
      end else if (timeout && oneshot) begin
        en <= 1'b0;
      end

      if (pre_wr)
        pre <= din;
      if (rl_wr)
        reload[7:0] <= din;

      // Placed after the counting updates so the write wins on a tick edge.
      if (rh_wr) begin
        reload[15:8] <= din;
        count        <= {din, reload[7:0]};
        pcnt         <= 8'h00;
      end

      if (rd) begin
        dout <= rdata;
        if (addr == 3'd5)
          shadow <= count[15:8];
      end
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - randomized bench for timer_irq against a behavioural model
module tb_timer_irq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;

  int checks = 0;
  int errors = 0;

  // Model state as plain integers.
  int m_en, m_ie, m_os, m_tf, m_pre, m_pc, m_rel, m_cnt, m_sh, m_dout;

  timer_irq dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_read(input int a);
    case (a)
      0: return m_en + 2 * m_ie + 4 * m_os;
      1: return m_tf;
      2: return m_pre;
      3: return m_rel % 256;
      4: return m_rel / 256;
      5: return m_cnt % 256;
      6: return m_sh;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_os = 0; m_tf = 0; m_pre = 0; m_pc = 0;
    m_rel = 0; m_cnt = 0; m_sh = 0; m_dout = 0;
  endtask

  // One clock of the timer rules, evaluated from the pre-edge state.
  task automatic model_step();
    int a, d, n_en, n_ie, n_os, n_tf, n_pre, n_pc, n_rel, n_cnt, n_sh, n_dout;
    bit wr, rd, live, tick, tout;
    if (rst) begin
      model_reset();
      return;
    end
    a = int'(addr); d = int'(din);
    wr = cs && we; rd = cs && !we;
    live = (m_en == 1) && !(wr && a == 0 && (d % 2) == 0);
    tick = live && (m_pc == m_pre);
    tout = tick && (m_cnt == 0);
    n_en = m_en; n_ie = m_ie; n_os = m_os; n_tf = m_tf; n_pre = m_pre;
    n_rel = m_rel; n_sh = m_sh; n_dout = m_dout;
    n_pc = (!live || tick) ? 0 : (m_pc + 1) % 256;
    n_cnt = !tick ? m_cnt : (m_cnt == 0 ? m_rel : m_cnt - 1);
    if (tout && m_os == 1) n_en = 0;
    if (wr && a == 1 && (d % 2) == 1) n_tf = 0;
    if (tout) n_tf = 1;
    if (wr) begin
      case (a)
        0: begin
          n_en = d % 2;
          n_ie = (d / 2) % 2;
`ifdef TIMER_ONESHOT_EN
          n_os = (d / 4) % 2;
`endif
        end
        2: n_pre = d;
        3: n_rel = (m_rel / 256) * 256 + d;
        4: begin
          n_rel = d * 256 + (m_rel % 256);
          n_cnt = n_rel;
          n_pc = 0;
        end
        default: ;
      endcase
    end
    if (rd) begin
      n_dout = model_read(a);
      if (a == 5) n_sh = m_cnt / 256;
    end
    m_en = n_en; m_ie = n_ie; m_os = n_os; m_tf = n_tf; m_pre = n_pre;
    m_pc = n_pc; m_rel = n_rel; m_cnt = n_cnt; m_sh = n_sh; m_dout = n_dout;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("dout_model", int'(dout), m_dout);
    check("irq_model", int'(irq), m_tf * m_ie);
  endtask

  task automatic bus(input bit w, input int a, input int d);
    cs = 1'b1; we = w; addr = 3'(a); din = 8'(d);
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    model_reset();

    do_reset();
    for (int a = 0; a < 8; a++) begin
      bus(1'b0, a, 0);
      check("reset_read", int'(dout), 0);
    end
    check("reset_irq", int'(irq), 0);

    // Periodic: PRE=3, RELOAD=4 -> 20-clock period.
    bus(1'b1, 2, 3);
    bus(1'b1, 3, 4);
    bus(1'b1, 4, 0);
    bus(1'b1, 0, 8'h03);
    wait_irq(n);
    check("first_period", n, 20);
    bus(1'b1, 1, 8'h01);
    check("irq_clear", int'(irq), 0);
    wait_irq(n);
    check("second_period", n + 1, 20);

    // Coherent 16-bit snapshot.
    do_reset();
    bus(1'b1, 2, 0);
    bus(1'b1, 3, 0);
    bus(1'b1, 0, 8'h01);
    bus(1'b1, 4, 8'h01);
    bus(1'b0, 5, 0);
    check("snap_lo", int'(dout), 8'h00);
    bus(1'b0, 6, 0);
    check("snap_hi", int'(dout), 8'h01);

    // Timeout every clock: clear on a timeout edge loses, IE gates irq.
    do_reset();
    bus(1'b1, 0, 8'h01);
    step();
    step();
    check("gated_irq", int'(irq), 0);
    bus(1'b1, 0, 8'h03);
    check("ie_irq", int'(irq), 1);
    bus(1'b1, 1, 8'h01);
    check("race_tf", int'(irq), 1);
    bus(1'b0, 1, 0);
    check("race_stat", int'(dout), 1);

    // One-shot or periodic, depending on build.
    do_reset();
    bus(1'b1, 3, 2);
    bus(1'b1, 4, 0);
    bus(1'b1, 0, 8'h07);
    wait_irq(n);
    check("oneshot_period", n, 3);
    bus(1'b0, 0, 0);
`ifdef TIMER_ONESHOT_EN
    check("ctrl_after_timeout", int'(dout), 8'h06);
`else
    check("ctrl_after_timeout", int'(dout), 8'h03);
`endif

    // Randomized bus traffic, small PRE/RELOAD so timeouts are frequent.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r, a, d;
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        do_reset();
      end else if (r < 30) begin
        a = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 255));
        if (a == 2 && $urandom_range(0, 3) != 0) d = int'($urandom_range(0, 3));
        if (a == 3) d = int'($urandom_range(0, 6));
        if (a == 4 && $urandom_range(0, 7) != 0) d = 0;
        if (a == 0 && $urandom_range(0, 3) != 0) d = d | 1;
        bus($urandom_range(0, 1) == 1, a, d);
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
